// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: cascaded multi-digit up/down cook-time counter.
// Optional auto-reload from the shadow register: BCD_TIMER_AUTORELOAD_EN.
module bcd_countdown_timer #(
   parameter int DIGITS  = 4,
   parameter int MODULUS = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_value,
   input  logic                up_down,
   input  logic                start,
   input  logic                stop,
   output logic [4*DIGITS-1:0] count_out,
   output logic                running,
   output logic                done,
   output logic                at_terminal
);

   localparam int         W      = 4 * DIGITS;
   localparam logic [3:0] LP_MAX = 4'(MODULUS - 1);
   localparam logic [W-1:0] LP_ALLMAX = {DIGITS{LP_MAX}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSED,
      S_DONE
   } state_t;

   state_t         r_state;
   logic [W-1:0]   r_count;
   logic [W-1:0]   r_shadow;
   logic           r_dir;
   logic           r_done;
   logic           r_running;

   logic [W-1:0]   w_clamped;
   logic [W-1:0]   w_next;
   logic [W-1:0]   w_term_cur;
   logic [W-1:0]   w_term_new;
   logic           w_next_term;
   logic           w_start_ok;

   // Digits above the legal range saturate at the top digit value.
   function automatic logic [W-1:0] f_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > LP_MAX) begin
            r[4*i +: 4] = LP_MAX;
         end
      end
      return r;
   endfunction

   // Decrement with borrow rippling from digit 0 upward.
   function automatic logic [W-1:0] f_down(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = LP_MAX;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Increment with carry rippling from digit 0 upward.
   function automatic logic [W-1:0] f_up(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == LP_MAX) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign w_clamped   = f_clamp(load_value);
   assign w_next      = r_dir ? f_up(r_count) : f_down(r_count);
   assign w_term_cur  = r_dir ? LP_ALLMAX : '0;
   assign w_term_new  = up_down ? LP_ALLMAX : '0;
   assign w_next_term = (w_next == w_term_cur);
   assign w_start_ok  = start &&
                        ((r_state == S_IDLE) || (r_state == S_PAUSED));

`ifdef BCD_TIMER_AUTORELOAD_EN
   logic w_shadow_term;
   assign w_shadow_term = (r_shadow == w_term_cur);
`else
   logic w_unused_shadow;
   assign w_unused_shadow = ^r_shadow;
`endif

   // Control FSM with count, shadow, direction and pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_shadow  <= '0;
         r_dir     <= 1'b0;
         r_done    <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (load && (r_state != S_RUN)) begin
            r_count   <= w_clamped;
            r_shadow  <= w_clamped;
            r_state   <= S_IDLE;
            r_running <= 1'b0;
         end else if (stop) begin
            if (r_state == S_RUN) begin
               r_state   <= S_PAUSED;
               r_running <= 1'b0;
            end
         end else if (w_start_ok) begin
            r_dir <= up_down;
            if (r_count == w_term_new) begin
               r_state   <= S_DONE;
               r_done    <= 1'b1;
               r_running <= 1'b0;
            end else begin
               r_state   <= S_RUN;
               r_running <= 1'b1;
            end
         end else if (tick && (r_state == S_RUN)) begin
            if (w_next_term) begin
               r_done <= 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
               if (w_shadow_term) begin
                  r_count   <= w_next;
                  r_state   <= S_DONE;
                  r_running <= 1'b0;
               end else begin
                  r_count <= r_shadow;
               end
`else
               r_count   <= w_next;
               r_state   <= S_DONE;
               r_running <= 1'b0;
`endif
            end else begin
               r_count <= w_next;
            end
         end
      end
   end

   assign count_out   = r_count;
   assign running     = r_running;
   assign done        = r_done;
   assign at_terminal = (r_count == w_term_cur);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed checks on a 4x mod-10 and a 2x mod-6 timer.
// Auto-reload expectations apply when BCD_TIMER_AUTORELOAD_EN is defined.
module tb_bcd_countdown_timer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic        load = 1'b0;
   logic        up_down = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] a_lv = '0;
   logic [7:0]  b_lv = '0;

   logic [15:0] a_cnt;
   logic        a_run;
   logic        a_done;
   logic        a_term;
   logic [7:0]  b_cnt;
   logic        b_run;
   logic        b_done;
   logic        b_term;

   int n_chk = 0;
   int n_err = 0;

   bcd_countdown_timer #(.DIGITS(4), .MODULUS(10)) u_dut (
      .clk(clk), .reset(reset), .tick(tick), .load(load),
      .load_value(a_lv), .up_down(up_down), .start(start),
      .stop(stop), .count_out(a_cnt), .running(a_run),
      .done(a_done), .at_terminal(a_term)
   );

   bcd_countdown_timer #(.DIGITS(2), .MODULUS(6)) u_dut6 (
      .clk(clk), .reset(reset), .tick(tick), .load(load),
      .load_value(b_lv), .up_down(up_down), .start(start),
      .stop(stop), .count_out(b_cnt), .running(b_run),
      .done(b_done), .at_terminal(b_term)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic do_load(input logic [15:0] a, input logic [7:0] b);
      a_lv = a;
      b_lv = b;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic do_start(input logic dir);
      up_down = dir;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         step();
      end
      tick = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_async_cnt", 32'(a_cnt), 32'h0);
      do_reset();
      chk("rst_cnt", 32'(a_cnt), 32'h0);
      chk("rst_run", 32'(a_run), 32'h0);
      chk("rst_done", 32'(a_done), 32'h0);
      chk("rst_term_down", 32'(a_term), 32'h1);

      // start when already terminal
      do_start(1'b0);
      chk("st_term_done", 32'(a_done), 32'h1);
      chk("st_term_run", 32'(a_run), 32'h0);
      step();
      chk("st_term_pulse", 32'(a_done), 32'h0);
      do_start(1'b1);
      chk("done_ign_start", 32'(a_run), 32'h0);

      // reset mid-count
      do_load(16'h0012, 8'h00);
      do_start(1'b0);
      ticks(3);
      chk("mid_cnt", 32'(a_cnt), 32'h0009);
      chk("mid_run", 32'(a_run), 32'h1);
      reset = 1'b1;
      #1;
      chk("mid_rst_cnt", 32'(a_cnt), 32'h0);
      chk("mid_rst_run", 32'(a_run), 32'h0);
      chk("mid_rst_done", 32'(a_done), 32'h0);
      step();
      reset = 1'b0;
      step();

      // down cascade
      do_load(16'h0100, 8'h00);
      do_start(1'b0);
      ticks(1);
      chk("dn_borrow", 32'(a_cnt), 32'h0099);
      ticks(98);
      chk("dn_one", 32'(a_cnt), 32'h0001);
      chk("dn_nodone", 32'(a_done), 32'h0);
      ticks(1);
      chk("dn_done", 32'(a_done), 32'h1);
`ifdef BCD_TIMER_AUTORELOAD_EN
      chk("dn_reload", 32'(a_cnt), 32'h0100);
      chk("dn_run", 32'(a_run), 32'h1);
`else
      chk("dn_zero", 32'(a_cnt), 32'h0000);
      chk("dn_run", 32'(a_run), 32'h0);
      chk("dn_term", 32'(a_term), 32'h1);
`endif
      step();
      chk("dn_pulse", 32'(a_done), 32'h0);

      // up, mod 6, two digits
      do_reset();
      do_load(16'h0000, 8'h04);
      do_start(1'b1);
      ticks(1);
      chk("up6_05", 32'(b_cnt), 32'h05);
      ticks(1);
      chk("up6_10", 32'(b_cnt), 32'h10);
      ticks(28);
      chk("up6_54", 32'(b_cnt), 32'h54);
      chk("up6_nodone", 32'(b_done), 32'h0);
      ticks(1);
      chk("up6_done", 32'(b_done), 32'h1);
`ifdef BCD_TIMER_AUTORELOAD_EN
      chk("up6_reload", 32'(b_cnt), 32'h04);
      ticks(1);
      chk("up6_again", 32'(b_cnt), 32'h05);
`else
      chk("up6_55", 32'(b_cnt), 32'h55);
      chk("up6_run", 32'(b_run), 32'h0);
      ticks(1);
      chk("up6_hold", 32'(b_cnt), 32'h55);
      chk("up6_pulse", 32'(b_done), 32'h0);
`endif

      // clamp and priority
      do_reset();
      do_load(16'hA3B7, 8'h7F);
      chk("clamp10", 32'(a_cnt), 32'h9397);
      chk("clamp6", 32'(b_cnt), 32'h55);
      stop = 1'b1;
      do_start(1'b0);
      stop = 1'b0;
      chk("ss_idle", 32'(a_run), 32'h0);
      chk("ss_cnt", 32'(a_cnt), 32'h9397);
      do_start(1'b0);
      ticks(1);
      chk("run_tick", 32'(a_cnt), 32'h9396);
      do_load(16'h1111, 8'h11);
      chk("run_load_ign", 32'(a_cnt), 32'h9396);
      chk("run_load_run", 32'(a_run), 32'h1);
      tick = 1'b1;
      do_start(1'b0);
      tick = 1'b0;
      chk("run_start_tick", 32'(a_cnt), 32'h9395);

      // pause / resume with direction change
      do_reset();
      do_load(16'h0005, 8'h00);
      tick = 1'b1;
      do_start(1'b0);
      tick = 1'b0;
      chk("start_tick_ign", 32'(a_cnt), 32'h0005);
      ticks(2);
      chk("pz_3", 32'(a_cnt), 32'h0003);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("pz_run", 32'(a_run), 32'h0);
      ticks(5);
      chk("pz_hold", 32'(a_cnt), 32'h0003);
      do_start(1'b1);
      chk("pz_resume", 32'(a_run), 32'h1);
      ticks(1);
      chk("pz_up", 32'(a_cnt), 32'h0004);

`ifdef BCD_TIMER_AUTORELOAD_EN
      do_reset();
      do_load(16'h0002, 8'h00);
      do_start(1'b0);
      ticks(1);
      chk("ar_1", 32'(a_cnt), 32'h0001);
      ticks(1);
      chk("ar_done", 32'(a_done), 32'h1);
      chk("ar_cnt", 32'(a_cnt), 32'h0002);
      chk("ar_run", 32'(a_run), 32'h1);
      ticks(1);
      chk("ar_nodone", 32'(a_done), 32'h0);
      ticks(1);
      chk("ar_done2", 32'(a_done), 32'h1);
      chk("ar_cnt2", 32'(a_cnt), 32'h0002);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit cascaded counter that generalises the single-digit mod-10 counter into the oven's cook-time engine.
- Supports DIGITS digits, per-digit modulus, up/down mode, load, start/stop control and a terminal-count "done" pulse.
- Advances only on an external one-cycle tick strobe (e.g. 1 Hz enable from the prescaler). Feeds the display driver and the oven control FSM.

Parameters:
- DIGITS, 4, number of cascaded digits; each digit is 4 bits wide.
- MODULUS, 10, per-digit modulus. Legal range 2..16; each digit counts 0..MODULUS-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  count-enable strobe, one clk cycle wide.
- load  input  1  load request.
- load_value  input  4*DIGITS  per-digit value; digit 0 is bits [3:0].
- up_down  input  1  1 = count up, 0 = count down. Sampled only when start is accepted.
- start  input  1  start/resume request.
- stop  input  1  pause request.
- count_out  output  4*DIGITS  current count, digit 0 in bits [3:0].
- running  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse when terminal count is reached.
- at_terminal  output  1  combinational; high when count_out equals the terminal value for the latched direction.

Behaviour:
- Reset (async, active-high): count_out=0, shadow register=0, direction latch=down, state=IDLE, running=0, done=0.
- States: IDLE, RUN, PAUSED, DONE. running = (state==RUN).
- Same-cycle priority: reset > load > stop > start > tick.
- Load:
  - Accepted in IDLE, PAUSED and DONE; ignored in RUN.
  - Any digit >= MODULUS is clamped to MODULUS-1.
  - Clamped value goes to both count_out and the shadow register on the next edge; state -> IDLE.
- Start:
  - Accepted in IDLE and PAUSED; latches up_down; state -> RUN.
  - Ignored in RUN and DONE.
  - If count_out already equals the terminal value for the new direction: state -> DONE, done pulses, count unchanged.
- Stop: RUN -> PAUSED, count frozen. Ignored in all other states. Stop wins over a same-cycle start.
- Counting:
  - Only in RUN, on a cycle with tick=1.
  - A tick in the same cycle that start is accepted is not counted.
- Down step:
  - Digit 0 decrements.
  - A digit at 0 becomes MODULUS-1 and borrows into the next digit.
  - Terminal value is all digits 0.
- Up step:
  - Digit 0 increments.
  - A digit at MODULUS-1 becomes 0 and carries into the next digit.
  - Terminal value is all digits MODULUS-1.
- Terminal: on the tick that makes count_out equal the terminal value:
  - done=1 for exactly the following cycle;
  - state -> DONE (see Optional Feature);
  - no further counting.
- Latency: count_out and done update one clk edge after the qualifying input; no combinational input->output paths except at_terminal.
- DONE: holds count_out. Exit only via load (-> IDLE) or reset.
- Reset asserted mid-RUN: immediate return to the reset values; the shadow register is also cleared.
- Width rule: all digit arithmetic is 4-bit modulo MODULUS; a cascade never produces a value >= MODULUS.

Optional Feature:
- Macro: BCD_TIMER_AUTORELOAD_EN.
- Defined: on reaching terminal in RUN:
  - done pulses as normal;
  - count_out reloads from the shadow register on the same edge;
  - state stays RUN.
  - Exception: if the shadow value itself equals the terminal value, go to DONE to avoid a zero-length loop.
- Undefined: shadow register still written on load, but never read back. Terminal always goes to DONE.

Test Plan:
- Reset mid-count: DIGITS=4, load 0x0012, start down, 3 ticks, then assert reset -> count_out=0x0000, running=0, done=0 immediately.
- Down cascade: load 0x0100, start down, 1 tick -> 0x0099; 99 more ticks -> 0x0000 with done high for exactly 1 cycle, state DONE, running=0.
- Up with MODULUS=6, DIGITS=2: load 0x04, start up; ticks give 0x05, 0x10 … 0x55 -> done pulse; a further tick leaves 0x55 unchanged.
- Clamp and priority: load 0xA3B7 with MODULUS=10 -> 0x9397. Same-cycle start+stop in IDLE -> stays IDLE. Load during RUN -> ignored.
- Pause/resume: run down from 0x0005; after 2 ticks stop -> 0x0003 held over 5 ticks. Start with up_down=1 -> next tick 0x0004.
- With BCD_TIMER_AUTORELOAD_EN: load 0x0002, start down, 2 ticks -> done pulse and count_out=0x0002, running=1. Next 2 ticks repeat the pulse.
